seq_booth_mul: RTL and testbench

//  Multi-cycle signed multiplier that produces results for the MiniAlu multiply write-back.
//  On iStart it takes the two RAM source operands and runs radix-4 Booth recoding, one digit per cycle.
//  It returns a 2*WIDTH product split into low and high halves.
//  The ALU writes oResultLo to the destination register and oResultHi through the RAM multiply port.

---
 rtl/seq_booth_mul.sv | 197 +++++++++++++++++++
 tb/tb_seq_booth_mul.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_booth_mul.sv
// -----------------------------------------------------------------------------
// seq_booth_mul
//
// Multi-cycle two's-complement multiplier for the MiniAlu multiply write-back.
// A start request latches both operands. The multiplier is then consumed as
// radix-4 Booth digits, one digit per clock. Each RUN cycle adds digit*A into
// the upper accumulator and arithmetically shifts the whole accumulator right
// by two. When the last digit has been consumed, the 2*WIDTH product is loaded
// into the result registers and oDone pulses for one cycle.
//
// Optional feature (macro MUL_UNSIGNED_EN):
//   Adds the input iUnsigned, which is sampled together with iStart.
//   With iUnsigned=1, both operands are zero-extended and one extra Booth step
//   is run, so the result is the unsigned product.
//   With the macro undefined, the port is absent and every operation is signed.
//
// Parameters
//   WIDTH  operand width (even, >= 4); the product is 2*WIDTH bits
//   CNT_W  digit counter width; 2**CNT_W >= WIDTH/2
//
// Ports
//   Clock      in   1      clock; all state changes on the rising edge
//   Reset      in   1      asynchronous reset, active low
//   iStart     in   1      start request; only sampled while idle
//   iOperandA  in   WIDTH  multiplicand
//   iOperandB  in   WIDTH  multiplier (Booth-recoded)
//   iUnsigned  in   1      unsigned operation (MUL_UNSIGNED_EN builds only)
//   oBusy      out  1      high while an operation is running or completing
//   oDone      out  1      one-cycle completion pulse; results valid from here
//   oResultLo  out  WIDTH  product[WIDTH-1:0]
//   oResultHi  out  WIDTH  product[2*WIDTH-1:WIDTH]
// -----------------------------------------------------------------------------
module seq_booth_mul #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iOperandA,
    input  logic [WIDTH-1:0] iOperandB,
`ifdef MUL_UNSIGNED_EN
    input  logic             iUnsigned,
`endif
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResultLo,
    output logic [WIDTH-1:0] oResultHi
);

    // The accumulator's upper half is two bits wider than an operand. This
    // leaves room for +/-2*A and for the -2^(W-1) * -2^(W-1) corner case.
    localparam int AW = WIDTH + 2;
    // The multiplier shift register also carries two extension bits. This
    // lets the unsigned build consume one more digit than the signed build.
    localparam int LW = WIDTH + 2;

`ifdef MUL_UNSIGNED_EN
    // The unsigned build needs to count to WIDTH/2, one past the signed maximum.
    localparam int CW = CNT_W + 1;
`else
    localparam int CW = CNT_W;
`endif

    localparam logic [CW-1:0] LAST_S = CW'(WIDTH / 2 - 1);
    localparam logic [CW-1:0] LAST_U = CW'(WIDTH / 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic        [CW-1:0] cnt;
    logic signed [AW-1:0] mcand;
    logic signed [AW-1:0] acc_hi;
    logic        [LW-1:0] acc_lo;
    logic                 acc_e;     // previous multiplier bit (Booth b[-1])
    logic                 uns_mode;  // mode of the running operation
    logic                 start_uns; // mode requested alongside iStart

    logic signed [AW-1:0]      pp;
    logic signed [AW-1:0]      sum;
    logic signed [AW-1:0]      hi_nx;
    logic        [LW-1:0]      lo_nx;
    logic                      e_nx;
    logic                      run_last;
    logic        [2*WIDTH-1:0] prod;

    // Radix-4 Booth digit selection: triplet {b[2i+1], b[2i], b[2i-1]}
    // maps to a digit in {-2,-1,0,+1,+2}, and the function returns digit*a.
    function automatic logic signed [AW-1:0] booth_pp(
        input logic        [2:0]    trip,
        input logic signed [AW-1:0] a
    );
        logic signed [AW-1:0] r;
        case (trip)
            3'b001, 3'b010: r = a;
            3'b011:         r = a <<< 1;
            3'b100:         r = -(a <<< 1);
            3'b101, 3'b110: r = -a;
            default:        r = '0;
        endcase
        return r;
    endfunction

`ifdef MUL_UNSIGNED_EN
    assign start_uns = iUnsigned;
`else
    assign start_uns = 1'b0;
`endif

    // ---- Booth step datapath: add digit*A, then shift {hi,lo,e} right by 2 ----
    always_comb begin
        pp    = booth_pp({acc_lo[1:0], acc_e}, mcand);
        sum   = acc_hi + pp;
        hi_nx = sum >>> 2;
        lo_nx = {sum[1:0], acc_lo[LW-1:2]};
        e_nx  = acc_lo[1];
    end

    assign run_last = (cnt == (uns_mode ? LAST_U : LAST_S));

    // After the last step, the signed build leaves the two multiplier extension
    // bits at the bottom of lo. The unsigned build has shifted them out.
    assign prod = uns_mode ? {hi_nx[WIDTH-3:0], lo_nx}
                           : {hi_nx[WIDTH-1:0], lo_nx[LW-1:2]};

    // ---- FSM: state register ----
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nx;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (iStart)   state_nx = RUN;
            RUN:     if (run_last) state_nx = DONE;
            DONE:                  state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        oBusy = (state != IDLE);
        oDone = (state == DONE);
    end

    // ---- Operand latch, accumulator and result registers ----
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt       <= '0;
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            acc_e     <= 1'b0;
            uns_mode  <= 1'b0;
            oResultLo <= '0;
            oResultHi <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        cnt      <= '0;
                        acc_hi   <= '0;
                        acc_e    <= 1'b0;
                        uns_mode <= start_uns;
                        if (start_uns) begin
                            mcand  <= {2'b00, iOperandA};
                            acc_lo <= {2'b00, iOperandB};
                        end else begin
                            mcand  <= {{2{iOperandA[WIDTH-1]}}, iOperandA};
                            acc_lo <= {{2{iOperandB[WIDTH-1]}}, iOperandB};
                        end
                    end
                end
                RUN: begin
                    acc_hi <= hi_nx;
                    acc_lo <= lo_nx;
                    acc_e  <= e_nx;
                    cnt    <= cnt + CW'(1);
                    if (run_last) begin
                        oResultLo <= prod[WIDTH-1:0];
                        oResultHi <= prod[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_booth_mul.sv
module tb_seq_booth_mul;

    localparam int W = 16;

    logic         Clock = 1'b0;
    logic         Reset = 1'b0;
    logic         iStart = 1'b0;
    logic [W-1:0] iOperandA = '0;
    logic [W-1:0] iOperandB = '0;
`ifdef MUL_UNSIGNED_EN
    logic         iUnsigned = 1'b0;
`endif
    logic         oBusy;
    logic         oDone;
    logic [W-1:0] oResultLo;
    logic [W-1:0] oResultHi;

    int n_vec = 0;
    int n_err = 0;
    logic [2*W-1:0] prev_res = '0;

    seq_booth_mul #(.WIDTH(W), .CNT_W(4)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iStart    (iStart),
        .iOperandA (iOperandA),
        .iOperandB (iOperandB),
`ifdef MUL_UNSIGNED_EN
        .iUnsigned (iUnsigned),
`endif
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oResultLo (oResultLo),
        .oResultHi (oResultHi)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic u);
        logic signed [2*W-1:0] sa, sb;
        if (u) return {{W{1'b0}}, a} * {{W{1'b0}}, b};
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    // Runs one operation. If inject is set, a second start with A=B=9 is
    // pulsed across edge 3. Afterwards the task checks that no further
    // completion appears.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic u,
                          input logic [2*W-1:0] exp, input logic inject);
        int lat;
        int extra;
        lat = 0;
        @(negedge Clock);
        iStart = 1'b1;
        iOperandA = a;
        iOperandB = b;
`ifdef MUL_UNSIGNED_EN
        iUnsigned = u;
`endif
        @(posedge Clock); #1;
        iStart = 1'b0;
        iOperandA = W'($urandom);
        iOperandB = W'($urandom);
`ifdef MUL_UNSIGNED_EN
        iUnsigned = 1'($urandom);
`endif
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            if (inject && i == 3) begin
                iStart = 1'b1;
                iOperandA = W'(9);
                iOperandB = W'(9);
            end
            @(posedge Clock); #1;
            iStart = 1'b0;
            chk("busy_run", oBusy, 1'b1);
            if (oDone) lat = i;
            else chk("hold", {oResultHi, oResultLo}, prev_res);
        end
        chk("latency", lat, u ? W/2 + 1 : W/2);
        chk("product", {oResultHi, oResultLo}, exp);
        @(posedge Clock); #1;
        chk("done_clr", oDone, 1'b0);
        chk("busy_clr", oBusy, 1'b0);
        prev_res = {oResultHi, oResultLo};
        if (inject) begin
            extra = 0;
            for (int i = 0; i < 14; i++) begin
                @(posedge Clock); #1;
                if (oDone) extra++;
            end
            chk("no_requeue", extra, 0);
            chk("keep_res", {oResultHi, oResultLo}, exp);
        end
    endtask

    initial begin
        logic [W-1:0] a, b;
        int extra;

        // Reset state
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_busy", oBusy, 1'b0);
        chk("rst_done", oDone, 1'b0);
        chk("rst_lo", oResultLo, '0);
        chk("rst_hi", oResultHi, '0);
        @(negedge Clock);
        Reset = 1'b1;

        // Directed values with fixed expected products
        run_op(16'd3,    16'd5,    1'b0, 32'h0000_000F, 1'b0);
        run_op(16'hFFF9, 16'd6,    1'b0, 32'hFFFF_FFD6, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 32'h4000_0000, 1'b0);
        run_op(16'h7FFF, 16'h7FFF, 1'b0, 32'h3FFF_0001, 1'b0);
        run_op(16'h8000, 16'h7FFF, 1'b0, 32'hC000_8000, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'h0000_0001, 1'b0);
        run_op(16'd0,    16'h8000, 1'b0, 32'h0000_0000, 1'b0);

        // A start request during RUN is ignored and not queued
        run_op(16'd2, 16'd2, 1'b0, 32'h0000_0004, 1'b1);

        // Reset asserted mid-run aborts the operation
        @(negedge Clock);
        iStart = 1'b1;
        iOperandA = 16'h1234;
        iOperandB = 16'h0F0F;
`ifdef MUL_UNSIGNED_EN
        iUnsigned = 1'b0;
`endif
        @(posedge Clock); #1;
        iStart = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk("abort_busy", oBusy, 1'b0);
        chk("abort_done", oDone, 1'b0);
        chk("abort_res", {oResultHi, oResultLo}, 32'h0);
        @(negedge Clock);
        Reset = 1'b1;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clock); #1;
            if (oDone) extra++;
        end
        chk("abort_nodone", extra, 0);
        prev_res = '0;
        run_op(16'd9, 16'hFFFD, 1'b0, 32'hFFFF_FFE5, 1'b0);

`ifdef MUL_UNSIGNED_EN
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'h0000_0001, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 1'b0);
`endif

        // Randomized operands against the reference model, with corner
        // values mixed in
        for (int k = 0; k < 40; k++) begin
            logic u;
            a = W'($urandom);
            b = W'($urandom);
            if (k % 8 == 0) a = 16'h8000;
            if (k % 8 == 1) b = 16'h8000;
            if (k % 8 == 2) b = 16'hFFFF;
            u = 1'b0;
`ifdef MUL_UNSIGNED_EN
            u = 1'($urandom);
`endif
            run_op(a, b, u, model(a, b, u), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
